// File: rtl/seg_pkg.sv
// Shared types and glyph table for the multiplexed 7-segment scan controller.
package seg_pkg;

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } phase_t;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_glyph(input logic [3:0] nibble);
        return SEG_GLYPH[nibble];
    endfunction

endpackage

// File: rtl/seg_lz_mask.sv
// Leading-zero suppression mask: flags upper zero digits with no nonzero digit above.
module seg_lz_mask #(
    parameter int unsigned NDIG = 4
) (
    input  logic [4*NDIG-1:0] din,
    input  logic [NDIG-1:0]   dp_in,
    input  logic              lz_en,
    output logic [NDIG-1:0]   suppress_c
);

    logic nz_above;

    // Walk from the most significant digit down; digit 0 is always shown.
    always_comb begin
        suppress_c = '0;
        nz_above   = 1'b0;
        for (int i = NDIG - 1; i >= 1; i--) begin
            suppress_c[i] = lz_en && (din[4*i +: 4] == 4'h0) && !nz_above && !dp_in[i];
            nz_above      = nz_above || (din[4*i +: 4] != 4'h0);
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode 7-segment driver with per-slot dead-time and
// per-frame snapshot of the display data.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NDIG        = 4,
    parameter int unsigned DIV         = 50000,
    parameter int unsigned BLANK       = 100,
    parameter int unsigned SEG_ACT_LOW = 1,
    parameter int unsigned AN_ACT_LOW  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*NDIG-1:0] din,
    input  logic [NDIG-1:0]   dp_in,
    input  logic [NDIG-1:0]   dig_en,
    input  logic              lz_en,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [NDIG-1:0]   an,
    output logic              frame_tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [6:0]      SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic            DP_OFF  = (SEG_ACT_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [NDIG-1:0] AN_OFF  = (AN_ACT_LOW != 0) ? {NDIG{1'b1}} : {NDIG{1'b0}};

    generate
        if ((NDIG < 1) || (BLANK < 1) || (DIV < BLANK + 2)) begin : g_bad_params
            $error("seg_scan_ctrl: illegal parameters (need NDIG>=1, BLANK>=1, DIV>=BLANK+2)");
        end
    endgenerate

    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic [4*NDIG-1:0] sh_din;
    logic [NDIG-1:0]   sh_dp;
    logic [NDIG-1:0]   sh_en;
    logic              sh_lz;

    logic              slot_end_c;
    logic              frame_end_c;
    phase_t            phase_c;
    logic [NDIG-1:0]   suppress_c;
    logic              lit_c;
    logic [3:0]        nib_c;
    logic [NDIG-1:0]   an_act_c;
    logic [NDIG-1:0]   an_nxt_c;
    logic [6:0]        seg_nxt_c;
    logic              dp_nxt_c;

    seg_lz_mask #(
        .NDIG (NDIG)
    ) u_lz_mask (
        .din        (sh_din),
        .dp_in      (sh_dp),
        .lz_en      (sh_lz),
        .suppress_c (suppress_c)
    );

    assign slot_end_c  = (cnt == CNT_W'(DIV - 1));
    assign frame_end_c = slot_end_c && (idx == IDX_W'(NDIG - 1));

    // Slot timing and digit pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= slot_end_c ? '0 : cnt + CNT_W'(1);
            if (frame_end_c) begin
                idx <= '0;
            end else if (slot_end_c) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

    // Display data is frozen for a whole frame so a frame never mixes old and new values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_din <= '0;
            sh_dp  <= '0;
            sh_en  <= '0;
            sh_lz  <= 1'b0;
        end else if (frame_end_c) begin
            sh_din <= din;
            sh_dp  <= dp_in;
            sh_en  <= dig_en;
            sh_lz  <= lz_en;
        end
    end

    always_comb begin
        phase_c   = (cnt < CNT_W'(BLANK)) ? PH_BLANK : PH_SHOW;
        nib_c     = sh_din[4*int'(idx) +: 4];
        lit_c     = (phase_c == PH_SHOW) && sh_en[idx] && !suppress_c[idx];
        an_act_c  = '0;
        an_act_c[idx] = lit_c;
        an_nxt_c  = an_act_c ^ AN_OFF;
        seg_nxt_c = (lit_c ? seg_glyph(nib_c) : 7'h00) ^ SEG_OFF;
        dp_nxt_c  = (lit_c && sh_dp[idx]) ^ DP_OFF;
    end

    // Pin registers: anodes and segments always update on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_nxt_c;
            seg        <= seg_nxt_c;
            dp         <= dp_nxt_c;
            frame_tick <= frame_end_c;
        end
    end

endmodule
